// File: rtl/nn_feature_loader.sv
// ---------------------------------------------------------------------------
// nn_feature_loader
//
// Upstream feeder for the neural_net core. Collects N_FEAT float32 feature
// words from a valid/ready stream into one frame, presents the frame as
// stable X inputs on x_flat, pulses nn_start, waits for nn_done, then holds
// the two captured logits on a valid/ready result port until consumed.
// Only one frame is in flight: loading resumes after the result is taken.
//
// Optional build macro:
//   FEAT_NAN_CHECK_EN - reject frames containing any Inf/NaN word
//                       (exponent field all ones) with a frame_err pulse.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   s_valid    feature word valid
//   s_ready    loader accepts a word this cycle (state-decoded only)
//   s_data     float32 feature word
//   s_last     final word of a frame
//   x_flat     feature frame, X_1 in bits [WORD_W-1:0], X_2 above, ...
//   nn_start   one-cycle start pulse to neural_net
//   nn_done    neural_net result valid (only looked at while waiting)
//   nn_o1      logit O_1 from neural_net
//   nn_o2      logit O_2 from neural_net
//   res_valid  captured logits available (registered)
//   res_ready  consumer accepts the result
//   res_o1     captured O_1
//   res_o2     captured O_2
//   frame_err  one-cycle pulse on a rejected (short/long/bad) frame
// ---------------------------------------------------------------------------
module nn_feature_loader #(
  parameter int N_FEAT = 16,
  parameter int WORD_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WORD_W-1:0]        s_data,
  input  logic                     s_last,
  output logic [N_FEAT*WORD_W-1:0] x_flat,
  output logic                     nn_start,
  input  logic                     nn_done,
  input  logic [WORD_W-1:0]        nn_o1,
  input  logic [WORD_W-1:0]        nn_o2,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WORD_W-1:0]        res_o1,
  output logic [WORD_W-1:0]        res_o2,
  output logic                     frame_err
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    DRAIN = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [IDX_W-1:0]           r_idx;
  logic [IDX_W-1:0]           w_idx_nxt;
  logic [N_FEAT*WORD_W-1:0]   r_x;
  logic [WORD_W-1:0]          r_o1;
  logic [WORD_W-1:0]          r_o2;
  logic                       r_res_valid;
  logic                       w_res_valid_nxt;
  logic                       r_err;
  logic                       w_err_nxt;
  logic                       w_accept;
  logic                       w_wr;
  logic                       w_cap;
  logic                       w_frame_bad;

  // Ready depends on state alone so upstream never sees a combinational
  // path from s_valid back to s_ready.
  assign s_ready  = (r_state == LOAD) || (r_state == DRAIN);
  assign w_accept = s_valid && s_ready;

  assign x_flat    = r_x;
  assign nn_start  = (r_state == START);
  assign res_valid = r_res_valid;
  assign res_o1    = r_o1;
  assign res_o2    = r_o2;
  assign frame_err = r_err;

`ifdef FEAT_NAN_CHECK_EN
  logic r_bad;
  logic w_bad_nxt;

  // The current word is folded in so an Inf/NaN in the final slot also
  // rejects the frame.
  assign w_frame_bad = r_bad || (&s_data[30:23]);

  always_comb begin
    w_bad_nxt = r_bad;
    if (w_wr) begin
      // Any frame end (short, complete, or overflowing into DRAIN) clears it.
      if (s_last || (r_idx == LAST_IDX)) w_bad_nxt = 1'b0;
      else                               w_bad_nxt = w_frame_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_bad <= 1'b0;
    else        r_bad <= w_bad_nxt;
  end
`else
  assign w_frame_bad = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  // Next-state and control decode
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_wr            = 1'b0;
    w_err_nxt       = 1'b0;
    w_cap           = 1'b0;
    w_res_valid_nxt = r_res_valid;
    case (r_state)
      LOAD: begin
        if (w_accept) begin
          w_wr = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            if (!s_last)          w_state_nxt = DRAIN;
            else if (w_frame_bad) w_err_nxt   = 1'b1;
            else                  w_state_nxt = START;
          end else if (s_last) begin
            w_idx_nxt = '0;
            w_err_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        // Overlong frame: swallow words until its s_last, then reject it.
        if (w_accept && s_last) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      START: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (nn_done) begin
          w_cap           = 1'b1;
          w_res_valid_nxt = 1'b1;
          w_state_nxt     = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          w_res_valid_nxt = 1'b0;
          w_state_nxt     = LOAD;
        end
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_x         <= '0;
      r_o1        <= '0;
      r_o2        <= '0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_idx       <= w_idx_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_err       <= w_err_nxt;
      // Only accepted LOAD words touch the frame, which keeps x_flat
      // frozen from START through HOLD.
      for (int i = 0; i < N_FEAT; i++) begin
        if (w_wr && (r_idx == IDX_W'(i))) r_x[i*WORD_W +: WORD_W] <= s_data;
      end
      if (w_cap) begin
        r_o1 <= nn_o1;
        r_o2 <= nn_o2;
      end
    end
  end

endmodule

// File: tb/tb_nn_feature_loader.sv
module tb_nn_feature_loader;
  localparam int N = 16;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           s_valid = 1'b0;
  logic           s_last = 1'b0;
  logic [W-1:0]   s_data = '0;
  logic           nn_done = 1'b0;
  logic [W-1:0]   nn_o1 = '0;
  logic [W-1:0]   nn_o2 = '0;
  logic           res_ready = 1'b0;
  logic           s_ready;
  logic [N*W-1:0] x_flat;
  logic           nn_start;
  logic           res_valid;
  logic [W-1:0]   res_o1;
  logic [W-1:0]   res_o2;
  logic           frame_err;

  nn_feature_loader #(.N_FEAT(N), .WORD_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .x_flat(x_flat), .nn_start(nn_start),
    .nn_done(nn_done), .nn_o1(nn_o1), .nn_o2(nn_o2), .res_valid(res_valid),
    .res_ready(res_ready), .res_o1(res_o1), .res_o2(res_o2),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_err = 0;
  int err_seen = 0;
  int start_seen = 0;

  logic [N*W-1:0] exp_x_q[$];
  logic [2*W-1:0] exp_res_q[$];
  logic [2*W-1:0] nn_resp_q[$];
  logic [W-1:0]   wbuf[32];

  task automatic check(input string name, input logic [N*W-1:0] act,
                       input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  function automatic logic [N*W-1:0] frame_of_buf();
    logic [N*W-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++) f[i*W +: W] = wbuf[i];
    return f;
  endfunction

  // Neural-net model: after a start, answer with the queued logits 3 cycles later.
  initial begin
    logic [2*W-1:0] r;
    forever begin
      @(negedge clk);
      if (rst_n && nn_start) begin
        r = (nn_resp_q.size() > 0) ? nn_resp_q.pop_front() : '0;
        repeat (3) @(posedge clk);
        #1;
        nn_o1 = r[2*W-1:W];
        nn_o2 = r[W-1:0];
        nn_done = 1'b1;
        @(posedge clk);
        #1;
        nn_done = 1'b0;
        nn_o1 = 32'hdeadbeef;
        nn_o2 = 32'hcafef00d;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic         p_start, p_err, p_hold;
    logic [W-1:0] p_o1, p_o2;
    logic [N*W-1:0] e;
    p_start = 0; p_err = 0; p_hold = 0; p_o1 = '0; p_o2 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_start = 0; p_err = 0; p_hold = 0;
      end else begin
        if (nn_start) begin
          start_seen++;
          if (p_start) fail_now("start_two_cycles");
          if (exp_x_q.size() == 0) fail_now("unexpected_start");
          else begin
            e = exp_x_q.pop_front();
            check("frame_x", x_flat, e);
          end
        end
        if (p_hold)
          check("res_hold", {res_valid, res_o1, res_o2}, {1'b1, p_o1, p_o2});
        if (res_valid && res_ready) begin
          if (exp_res_q.size() == 0) fail_now("unexpected_result");
          else begin
            e = '0;
            e[2*W-1:0] = exp_res_q.pop_front();
            check("result", {res_o1, res_o2}, e);
          end
        end
        if (frame_err) begin
          err_seen++;
          if (p_err) fail_now("err_two_cycles");
        end
        p_start = nn_start;
        p_err   = frame_err;
        p_hold  = res_valid && !res_ready;
        p_o1    = res_o1;
        p_o2    = res_o2;
      end
    end
  end

  task automatic send_word(input logic [W-1:0] d, input logic last, output int waited);
    s_valid = 1'b1; s_data = d; s_last = last; waited = 0;
    @(negedge clk);
    while (!s_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!s_ready) fail_now("s_ready_timeout");
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at, input bit gaps,
                            output int max_wait);
    int w;
    max_wait = 0;
    for (int i = 0; i < n; i++) begin
      send_word(wbuf[i], (i == last_at - 1), w);
      if (w > max_wait) max_wait = w;
      if (gaps && i != n - 1) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic expect_frame(input logic [W-1:0] o1, input logic [W-1:0] o2);
    exp_x_q.push_back(frame_of_buf());
    nn_resp_q.push_back({o1, o2});
    exp_res_q.push_back({o1, o2});
  endtask

  task automatic finish_result(input int hold);
    int t;
    t = 0;
    @(negedge clk);
    while (!res_valid && t < 100) begin t++; @(negedge clk); end
    if (!res_valid) fail_now("res_valid_timeout");
    if (hold == 0) begin @(posedge clk); #1; end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("res_valid_held", res_valid, 1'b1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("res_valid_cleared", res_valid, 1'b0);
    check("s_ready_after_hold", s_ready, 1'b1);
  endtask

  task automatic fill_buf(input logic [W-1:0] base);
    for (int i = 0; i < 32; i++) wbuf[i] = base + W'(i) * 32'h00010203;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mw, st0, t;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x_flat", x_flat, '0);
    check("rst_ctrl", {nn_start, res_valid, frame_err, s_ready}, 4'b0001);
    check("rst_res", {res_o1, res_o2}, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal frame with result hold
    for (int i = 0; i < N; i++) wbuf[i] = 32'h3e000000 + W'(i) * 32'h00111111;
    wbuf[0]  = 32'hbff89375;
    wbuf[1]  = 32'h3f1e6320;
    wbuf[15] = 32'hbec9ba5e;
    expect_frame(32'h3f800000, 32'hbf800000);
    send_frame(16, 16, 1'b0, mw);
    check("nn_start_T1", nn_start, 1'b1);
    check("x1", x_flat[31:0], 32'hbff89375);
    check("x16", x_flat[511:480], 32'hbec9ba5e);
    @(posedge clk); #1;
    check("nn_start_T2", nn_start, 1'b0);
    finish_result(5);

    // Short frame, then a good frame
    fill_buf(32'h40100000);
    st0 = start_seen;
    send_frame(7, 7, 1'b0, mw);
    exp_err++;
    repeat (3) @(posedge clk); #1;
    check("short_err", err_seen, exp_err);
    check("short_no_start", start_seen, st0);
    fill_buf(32'h3c200000);
    expect_frame(32'h3f000000, 32'h40400000);
    send_frame(16, 16, 1'b1, mw);
    finish_result(0);

    // Long frame: 20 words, s_last on 20
    fill_buf(32'h41000000);
    st0 = start_seen;
    send_frame(20, 20, 1'b0, mw);
    exp_err++;
    check("long_s_ready_stays", mw, 0);
    repeat (3) @(posedge clk); #1;
    check("long_err", err_seen, exp_err);
    check("long_no_start", start_seen, st0);

    // Backpressure with reset at word 9
    fill_buf(32'h3a500000);
    send_frame(8, 99, 1'b1, mw);
    s_valid = 1'b1; s_data = wbuf[8]; s_last = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_x_flat", x_flat, '0);
    check("midrst_ctrl", {nn_start, res_valid, frame_err, s_ready}, 4'b0001);
    s_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    fill_buf(32'h3b600000);
    expect_frame(32'hc0000000, 32'h3e800000);
    send_frame(16, 16, 1'b1, mw);
    finish_result(0);

    // Inf/NaN in word 4
    fill_buf(32'h3d700000);
    wbuf[3] = 32'h7fc00000;
    st0 = start_seen;
`ifdef FEAT_NAN_CHECK_EN
    send_frame(16, 16, 1'b0, mw);
    exp_err++;
    repeat (3) @(posedge clk); #1;
    check("nan_err", err_seen, exp_err);
    check("nan_no_start", start_seen, st0);
`else
    expect_frame(32'h3f400000, 32'hbf400000);
    send_frame(16, 16, 1'b0, mw);
    finish_result(0);
    check("nan_passes_start", start_seen, st0 + 1);
`endif

    t = 0;
    repeat (10) @(posedge clk);
    #1;
    check("end_exp_x_empty", exp_x_q.size(), 0);
    check("end_exp_res_empty", exp_res_q.size(), 0);
    check("end_err_total", err_seen, exp_err);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nn_feature_loader.md
Name: nn_feature_loader

Overview:
- Upstream feeder for the chatbot neural_net core.
- Accepts a stream of IEEE-754 float32 feature words (embedding of one utterance) over a valid/ready handshake and assembles one 16-entry feature frame.
- Presents the frame as stable X inputs, pulses a start, waits for the net's done, then captures the two float32 logits for a consumer behind a valid/ready result port.
- Replaces the hard-coded constant feature vector used for bring-up.

Parameters:
- N_FEAT, 16, features per frame; drives X_1..X_N_FEAT via x_flat.
- WORD_W, 32, bits per feature word and per logit (float32).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  feature word valid.
- s_ready  out  1  loader accepts a word this cycle.
- s_data  in  WORD_W  float32 feature word.
- s_last  in  1  marks the final word of a frame.
- x_flat  out  N_FEAT*WORD_W  feature frame; bits [31:0] are X_1, [63:32] are X_2, and so on.
- nn_start  out  1  one-cycle start pulse to neural_net.
- nn_done  in  1  neural_net result valid (single-cycle or level; sampled only in WAIT).
- nn_o1  in  WORD_W  logit O_1 from neural_net.
- nn_o2  in  WORD_W  logit O_2 from neural_net.
- res_valid  out  1  captured logits available.
- res_ready  in  1  consumer accepts the result.
- res_o1  out  WORD_W  captured O_1.
- res_o2  out  WORD_W  captured O_2.
- frame_err  out  1  one-cycle pulse on a rejected frame.

Behaviour:
- Reset (async assert, sync release): state LOAD, idx=0, x_flat=0, res_o1/res_o2=0, nn_start=0, res_valid=0, frame_err=0. Reset mid-frame or mid-WAIT discards everything.
- Handshake: a word transfers when s_valid && s_ready. s_ready is 1 only in LOAD and DRAIN. s_ready is combinational from state only, never from s_valid.
- Results: res_valid is registered. Once high it stays high, with res_o1/res_o2 stable, until res_valid && res_ready.

FSM states LOAD, DRAIN, START, WAIT, HOLD:
- LOAD, word accepted, writes feature[idx] <= s_data, then:
  - idx<N_FEAT-1 and s_last=0: idx++.
  - idx<N_FEAT-1 and s_last=1: short frame. Pulse frame_err, idx<=0, stay LOAD.
  - idx==N_FEAT-1 and s_last=1: go to START, idx<=0.
  - idx==N_FEAT-1 and s_last=0: long frame. Go to DRAIN, idx<=0.
- DRAIN: accept and discard words. On an accepted word with s_last=1, pulse frame_err and go to LOAD.
- START: nn_start=1 for exactly one cycle, then WAIT.
- WAIT: when nn_done=1, capture res_o1<=nn_o1 and res_o2<=nn_o2, set res_valid=1, go to HOLD. No timeout; the loader waits indefinitely.
- HOLD: on res_ready=1, clear res_valid and go to LOAD. A frame can therefore load only after the result is consumed, giving one frame in flight.
- x_flat stability: x_flat changes only on accepted LOAD writes. It is stable from entering START until the next accepted word after HOLD.
- Latency: last word accepted at cycle T -> nn_start at T+1 -> nn_done seen at cycle D -> res_valid at D+1.
- Simultaneous events: nn_done during START is ignored. res_ready outside HOLD is ignored. A failed frame still leaves any partially written x_flat entries updated, but nn_start does not fire.

Optional Feature:
- Macro: FEAT_NAN_CHECK_EN.
- Defined:
  - Each accepted LOAD word with exponent bits [30:23]==8'hFF (Inf/NaN) sets a sticky bad flag.
  - At the frame's final word, bad=1 pulses frame_err and returns to LOAD instead of START.
  - bad is cleared on every frame end and on reset.
- Undefined: no exponent checking; Inf/NaN words pass through to neural_net unchanged.

Test Plan:
- Normal frame: send 16 words 32'hbff89375, 32'h3f1e6320, ... 32'hbec9ba5e, s_last on word 16 -> x_flat[31:0]=32'hbff89375, x_flat[511:480]=32'hbec9ba5e, nn_start high exactly one cycle at T+1.
- Result capture: drive nn_done=1 with nn_o1=32'h3f800000 and nn_o2=32'hbf800000, hold res_ready=0 for 5 cycles -> res_valid held 5+ cycles with values stable; res_ready=1 -> res_valid=0 next cycle, s_ready=1.
- Short frame: s_last on word 7 -> frame_err pulse, no nn_start; the next full 16-word frame completes normally.
- Long frame: 20 words with s_last on word 20 -> s_ready stays 1 through DRAIN, frame_err on word 20, no nn_start.
- Backpressure and reset: toggle s_valid randomly during a frame with rst_n pulsed low at word 9 -> all outputs at reset values immediately; a fresh 16-word frame then succeeds with idx starting at 0.
- FEAT_NAN_CHECK_EN defined: word 4 = 32'h7fc00000 -> frame_err at word 16, no nn_start. Undefined: the same frame produces nn_start.
